axi_rd_data_router: RTL and testbench

Routes read-data beats from one upstream AXI R channel to `NUM_PORTS` downstream requesters: the CNN weight, feature and bias loaders share a single AXI master. The target port comes from the upper rid bits. The block locks on a burst until rlast and registers each port's output (1-deep slice). It sits between the shared AXI master R channel and the loader read-data inputs.

---
 rtl/axi_rd_data_router.sv | 181 ++++++++++++++++++
 tb/tb_axi_rd_data_router.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_data_router.sv
// axi_rd_data_router
//
// Routes read-data beats from one shared AXI R channel to NUM_PORTS
// downstream loaders (CNN weight / feature / bias). The destination port is
// taken from the upper SEL_W bits of rid on the first beat of a burst. The
// router then stays locked to that port until the rlast beat. Every port has
// its own 1-deep output register slice, so a stalled port only blocks the
// upstream while the upstream is targeting it.
//
// Optional feature macro: AXI_RD_ROUTER_RESP_CNT_EN
//   When defined, adds resp_err_cnt. This is a 16-bit saturating count of
//   accepted beats whose rresp[1] is set (SLVERR/DECERR), and it includes
//   dropped beats.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_r*                  upstream R channel (valid/ready handshake)
//   m_rvalid/m_rready     per-port handshake, bit p = port p
//   m_rid..m_ruser        per-port payload, packed, port p at slice p
//   burst_active          port p currently owns the upstream
//   proto_err             sticky: rid changed mid-burst or select out of range
//   resp_err_cnt          (macro only) error-response beat counter
module axi_rd_data_router #(
    parameter int DATA_WIDTH   = 32,
    parameter int ID_MAX_WIDTH = 12,
    parameter int NUM_PORTS    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_rvalid,
    input  logic [ID_MAX_WIDTH-1:0]            s_rid,
    input  logic [DATA_WIDTH-1:0]              s_rdata,
    input  logic [1:0]                         s_rresp,
    input  logic                               s_rlast,
    input  logic                               s_ruser,
    output logic                               s_rready,
    output logic [NUM_PORTS-1:0]               m_rvalid,
    input  logic [NUM_PORTS-1:0]               m_rready,
    output logic [NUM_PORTS*ID_MAX_WIDTH-1:0]  m_rid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    m_rdata,
    output logic [NUM_PORTS*2-1:0]             m_rresp,
    output logic [NUM_PORTS-1:0]               m_rlast,
    output logic [NUM_PORTS-1:0]               m_ruser,
    output logic [NUM_PORTS-1:0]               burst_active,
    output logic                               proto_err
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
    ,
    output logic [15:0]                        resp_err_cnt
`endif
);

    localparam int SEL_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel, tgt, lock_port_q;
    logic [ID_MAX_WIDTH-1:0] lock_id_q;
    logic                    sel_ok, deliver, set_err, accept, tgt_free;
    logic [NUM_PORTS-1:0]    tgt_oh, slot_free, load;

    assign sel = s_rid[ID_MAX_WIDTH-1 -: SEL_W];
    // While streaming the rid is ignored for routing; only the locked port counts.
    assign tgt = (state_q == STREAM) ? lock_port_q : sel;

    always_comb begin
        sel_ok = 1'b0;
        tgt_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == i[SEL_W-1:0]) sel_ok = 1'b1;
            if (tgt == i[SEL_W-1:0]) tgt_oh[i] = 1'b1;
        end
    end

    // A slice can take a new beat when empty or when draining this cycle.
    assign tgt_free = |(tgt_oh & slot_free);
    assign accept   = s_rvalid & s_rready;
    assign load     = tgt_oh & {NUM_PORTS{accept & deliver}};

    always_comb begin
        state_d  = state_q;
        s_rready = 1'b0;
        deliver  = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_rvalid) begin
                    if (sel_ok) begin
                        s_rready = tgt_free;
                        deliver  = 1'b1;
                    end else begin
                        s_rready = 1'b1;
                        set_err  = 1'b1;
                    end
                    if (s_rready && !s_rlast) state_d = sel_ok ? STREAM : DROP;
                end
            end
            STREAM: begin
                s_rready = tgt_free;
                deliver  = 1'b1;
                if (s_rvalid && s_rready) begin
                    if (s_rid != lock_id_q) set_err = 1'b1;
                    if (s_rlast) state_d = IDLE;
                end
            end
            DROP: begin
                s_rready = 1'b1;
                if (s_rvalid && s_rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_port_q <= '0;
            lock_id_q   <= '0;
            proto_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && accept && sel_ok) begin
                lock_port_q <= sel;
                lock_id_q   <= s_rid;
            end
            if (set_err) proto_err <= 1'b1;
        end
    end

    // ---- stage p1: per-port output slices ----
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slice
        localparam logic [SEL_W-1:0] PIDX = SEL_W'(p);

        logic                    vld_p1;
        logic [ID_MAX_WIDTH-1:0] id_p1;
        logic [DATA_WIDTH-1:0]   data_p1;
        logic [1:0]              resp_p1;
        logic                    last_p1;
        logic                    user_p1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1  <= 1'b0;
                id_p1   <= '0;
                data_p1 <= '0;
                resp_p1 <= '0;
                last_p1 <= 1'b0;
                user_p1 <= 1'b0;
            end else if (load[p]) begin
                vld_p1  <= 1'b1;
                id_p1   <= s_rid;
                data_p1 <= s_rdata;
                resp_p1 <= s_rresp;
                last_p1 <= s_rlast;
                user_p1 <= s_ruser;
            end else if (m_rready[p]) begin
                vld_p1 <= 1'b0;
            end
        end

        assign slot_free[p]                              = !vld_p1 || m_rready[p];
        assign m_rvalid[p]                               = vld_p1;
        assign m_rid[p*ID_MAX_WIDTH +: ID_MAX_WIDTH]     = id_p1;
        assign m_rdata[p*DATA_WIDTH +: DATA_WIDTH]       = data_p1;
        assign m_rresp[p*2 +: 2]                         = resp_p1;
        assign m_rlast[p]                                = last_p1;
        assign m_ruser[p]                                = user_p1;
        assign burst_active[p] = (state_q == STREAM && lock_port_q == PIDX) ||
                                 (vld_p1 && !last_p1);
    end

`ifdef AXI_RD_ROUTER_RESP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            resp_err_cnt <= '0;
        else if (accept && s_rresp[1] && resp_err_cnt != 16'hFFFF)
            resp_err_cnt <= resp_err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axi_rd_data_router.sv
module tb_axi_rd_data_router;
    localparam int NP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 4-port instance
    logic        s_rvalid, s_rlast, s_ruser, s_rready, proto_err;
    logic [11:0] s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [3:0]  m_rvalid, m_rready, m_rlast, m_ruser, burst_active;
    logic [47:0] m_rid;
    logic [127:0] m_rdata;
    logic [7:0]  m_rresp;
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
    logic [15:0] resp_err_cnt, resp_err_cnt3;
`endif

    // 3-port instance (out-of-range select)
    logic        s3_rvalid, s3_rlast, s3_ruser, s3_rready, proto3;
    logic [11:0] s3_rid;
    logic [31:0] s3_rdata;
    logic [1:0]  s3_rresp;
    logic [2:0]  m3_rvalid, m3_rready, m3_rlast, m3_ruser, ba3;
    logic [35:0] m3_rid;
    logic [95:0] m3_rdata;
    logic [5:0]  m3_rresp;

    axi_rd_data_router #(.DATA_WIDTH(32), .ID_MAX_WIDTH(12), .NUM_PORTS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_ruser(s_ruser), .s_rready(s_rready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_ruser(m_ruser),
        .burst_active(burst_active), .proto_err(proto_err)
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
        , .resp_err_cnt(resp_err_cnt)
`endif
    );

    axi_rd_data_router #(.DATA_WIDTH(32), .ID_MAX_WIDTH(12), .NUM_PORTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_rvalid(s3_rvalid), .s_rid(s3_rid), .s_rdata(s3_rdata), .s_rresp(s3_rresp),
        .s_rlast(s3_rlast), .s_ruser(s3_ruser), .s_rready(s3_rready),
        .m_rvalid(m3_rvalid), .m_rready(m3_rready), .m_rid(m3_rid), .m_rdata(m3_rdata),
        .m_rresp(m3_rresp), .m_rlast(m3_rlast), .m_ruser(m3_ruser),
        .burst_active(ba3), .proto_err(proto3)
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
        , .resp_err_cnt(resp_err_cnt3)
`endif
    );

    int   vectors = 0;
    int   miscompares = 0;
    logic rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference model: per-port queues of expected beats. A burst's port is
    // fixed by the rid of its first beat and held until the rlast beat.
    logic [47:0] q [NP][$];
    logic        in_burst = 1'b0;
    logic [1:0]  lock = 2'd0;
    int          errcnt_model = 0;
    logic [47:0] obs_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) q[p].delete();
            in_burst     = 1'b0;
            errcnt_model = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (m_rvalid[p]) begin
                    chk("spurious_vld", 64'(q[p].size() != 0), 64'd1);
                    if (q[p].size() != 0) begin
                        obs_beat = {m_rid[p*12 +: 12], m_rdata[p*32 +: 32],
                                    m_rresp[p*2 +: 2], m_rlast[p], m_ruser[p]};
                        chk("beat_payload", 64'(obs_beat), 64'(q[p][0]));
                        if (m_rready[p]) void'(q[p].pop_front());
                    end
                end
            end
            if (s_rvalid && s_rready) begin
                if (!in_burst) lock = s_rid[11:10];
                q[lock].push_back({s_rid, s_rdata, s_rresp, s_rlast, s_ruser});
                in_burst = !s_rlast;
                if (s_rresp[1]) errcnt_model++;
            end
        end
    end

    task automatic send_beat(input logic [11:0] id, input logic [31:0] d,
                             input logic [1:0] r, input logic l, output int waited);
        s_rvalid = 1'b1; s_rid = id; s_rdata = d; s_rresp = r; s_rlast = l;
        s_ruser = 1'($urandom);
        waited = 0;
        @(negedge clk);
        while (!s_rready && waited < 50) begin
            @(posedge clk); #1;
            if (rand_rdy) m_rready = 4'($urandom);
            @(negedge clk);
            waited++;
        end
        chk("handshake_timeout", 64'(s_rready), 64'd1);
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rlast = 1'b0;
        if (rand_rdy) m_rready = 4'($urandom);
    endtask

    task automatic send_burst(input logic [11:0] id, input int len, input logic [1:0] r);
        int w;
        for (int i = 0; i < len; i++) send_beat(id, $urandom, r, (i == len - 1), w);
    endtask

    initial begin
        int w;
        logic [31:0] bp [8];
        logic [31:0] d3;
        int port, len;

        rst_n = 1'b0;
        s_rvalid = 0; s_rid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_ruser = 0;
        m_rready = 4'h0;
        s3_rvalid = 0; s3_rid = 0; s3_rdata = 0; s3_rresp = 0; s3_rlast = 0; s3_ruser = 0;
        m3_rready = 3'h7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_s_rready", 64'(s_rready), 64'd0);
        chk("rst_burst_active", 64'(burst_active), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata[63:0]), 64'd0);
        chk("rst_proto3", 64'(proto3), 64'd0);
        rst_n = 1'b1;
        m_rready = 4'hF;
        @(posedge clk); #1;

        // Single port, 4-beat burst to port 1
        send_beat(12'h400, 32'h1111_0000, 2'b00, 1'b0, w);
        chk("single_first_vld", 64'(m_rvalid), 64'b0010);
        chk("single_burst_active", 64'(burst_active), 64'b0010);
        send_beat(12'h400, 32'h1111_0001, 2'b00, 1'b0, w);
        send_beat(12'h400, 32'h1111_0002, 2'b00, 1'b0, w);
        chk("single_mid_burst_active", 64'(burst_active[1]), 64'd1);
        send_beat(12'h400, 32'h1111_0003, 2'b00, 1'b1, w);
        chk("single_last_vld", 64'({m_rvalid, m_rlast[1]}), 64'b00101);
        chk("single_end_burst_active", 64'(burst_active), 64'd0);
        chk("single_proto_err", 64'(proto_err), 64'd0);

        // Back-pressure on port 2 in the middle of an 8-beat burst
        for (int i = 0; i < 8; i++) bp[i] = $urandom;
        for (int i = 0; i < 3; i++) send_beat(12'h800, bp[i], 2'b00, 1'b0, w);
        m_rready = 4'b1011;
        s_rvalid = 1'b1; s_rid = 12'h800; s_rdata = bp[3]; s_rresp = 0; s_rlast = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_s_rready_low", 64'(s_rready), 64'd0);
            chk("bp_slice_held", 64'(m_rvalid[2]), 64'd1);
            @(posedge clk); #1;
        end
        m_rready = 4'hF;
        for (int i = 3; i < 8; i++) send_beat(12'h800, bp[i], 2'b00, (i == 7), w);

        // Interleaved single-beat bursts to ports 0,3,1,2
        send_beat(12'h000, 32'hA0, 2'b00, 1'b1, w); chk("il_p0_nowait", 64'(w), 64'd0);
        send_beat(12'hC00, 32'hA3, 2'b00, 1'b1, w); chk("il_p3_nowait", 64'(w), 64'd0);
        send_beat(12'h400, 32'hA1, 2'b00, 1'b1, w); chk("il_p1_nowait", 64'(w), 64'd0);
        send_beat(12'h800, 32'hA2, 2'b00, 1'b1, w); chk("il_p2_nowait", 64'(w), 64'd0);
        chk("il_m_rvalid", 64'(m_rvalid), 64'b0100);
        chk("il_burst_active", 64'(burst_active), 64'd0);

        // Randomised bursts with random per-port ready
        rand_rdy = 1'b1;
        for (int b = 0; b < 30; b++) begin
            port = $urandom_range(0, 3);
            len  = $urandom_range(1, 6);
            send_burst({port[1:0], 10'($urandom)}, len, 2'($urandom));
        end
        rand_rdy = 1'b0;
        m_rready = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) chk("rand_drained", 64'(q[p].size()), 64'd0);
        chk("rand_proto_err", 64'(proto_err), 64'd0);
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
        chk("rand_resp_cnt", 64'(resp_err_cnt), 64'(errcnt_model));
`endif

        // Mid-burst rid change: all beats stay on port 0
        send_beat(12'h000, 32'hB0, 2'b00, 1'b0, w);
        chk("ridchg_no_err_yet", 64'(proto_err), 64'd0);
        send_beat(12'h001, 32'hB1, 2'b00, 1'b0, w);
        chk("ridchg_err", 64'(proto_err), 64'd1);
        send_beat(12'hC00, 32'hB2, 2'b00, 1'b0, w);
        chk("ridchg_stays_p0", 64'(m_rvalid), 64'b0001);
        send_beat(12'h000, 32'hB3, 2'b00, 1'b1, w);
        send_burst(12'h400, 2, 2'b00);
        chk("ridchg_sticky", 64'(proto_err), 64'd1);

        // Out-of-range select on the 3-port instance
        s3_rvalid = 1'b1; s3_rid = 12'hC00; s3_rdata = 32'hDEAD; s3_rlast = 1'b0;
        @(negedge clk);
        chk("drop_b0_ready", 64'(s3_rready), 64'd1);
        @(posedge clk); #1;
        s3_rdata = 32'hBEEF; s3_rlast = 1'b1;
        @(negedge clk);
        chk("drop_b1_ready", 64'(s3_rready), 64'd1);
        chk("drop_b1_no_vld", 64'(m3_rvalid), 64'd0);
        @(posedge clk); #1;
        s3_rvalid = 1'b0; s3_rlast = 1'b0;
        chk("drop_after_no_vld", 64'(m3_rvalid), 64'd0);
        chk("drop_proto_err", 64'(proto3), 64'd1);
        d3 = $urandom;
        s3_rvalid = 1'b1; s3_rid = 12'h000; s3_rdata = d3; s3_rlast = 1'b1;
        @(negedge clk);
        chk("drop_next_ready", 64'(s3_rready), 64'd1);
        @(posedge clk); #1;
        s3_rvalid = 1'b0; s3_rlast = 1'b0;
        chk("drop_next_vld", 64'(m3_rvalid), 64'b001);
        chk("drop_next_data", 64'(m3_rdata[31:0]), 64'(d3));
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
        chk("drop_resp_cnt3", 64'(resp_err_cnt3), 64'd0);
`endif

        // Reset in the middle of a 4-beat error-response burst
        chk("pre_rst_proto_err", 64'(proto_err), 64'd1);
        send_beat(12'h400, 32'hC0, 2'b10, 1'b0, w);
        send_beat(12'h400, 32'hC1, 2'b10, 1'b0, w);
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
        chk("pre_rst_resp_cnt", 64'(resp_err_cnt), 64'(errcnt_model));
`endif
        rst_n = 1'b0;
        #1;
        chk("mrst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("mrst_s_rready", 64'(s_rready), 64'd0);
        chk("mrst_burst_active", 64'(burst_active), 64'd0);
        chk("mrst_proto_err", 64'(proto_err), 64'd0);
        chk("mrst_m_rdata", 64'(m_rdata[63:32]), 64'd0);
        chk("mrst_m_rid", 64'(m_rid), 64'd0);
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
        chk("mrst_resp_cnt", 64'(resp_err_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_beat(12'h400, 32'hC2, 2'b10, 1'b0, w);
        chk("post_rst_new_burst", 64'(burst_active), 64'b0010);
        send_beat(12'h400, 32'hC3, 2'b10, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) chk("post_rst_drained", 64'(q[p].size()), 64'd0);
`ifdef AXI_RD_ROUTER_RESP_CNT_EN
        chk("post_rst_resp_cnt", 64'(resp_err_cnt), 64'(errcnt_model));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
